// File: rtl/sdram_cmd_sched.sv
// Arbitrates the shared 16-bit SDRAM controller port between the video refill queue
// and the cache line fill/write-back, tracks data beats and owns the wrapping video line address.
module sdram_cmd_sched #(
  parameter logic [14:0] VID_BASE   = 15'h6FF8,
  parameter logic [11:0] VID_LAST   = 12'd3071,
  parameter int          VID_BEATS  = 16,
  parameter int          LINE_BEATS = 128,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_req,
  input  logic        cache_wr_req,
  input  logic        cache_rd_req,
  input  logic [11:0] cache_waddr,
  input  logic [11:0] cache_raddr,
  output logic [1:0]  sys_cmd,
  output logic [17:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_fill_we,
  output logic        cache_drain_re,
  output logic        vq_we,
  output logic [31:0] vq_data,
  output logic [11:0] vid_adr,
  output logic        busy
);

  localparam int BW = $clog2((VID_BEATS > LINE_BEATS ? VID_BEATS : LINE_BEATS) + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;
  typedef enum logic [1:0] {OWN_VID, OWN_CWR, OWN_CRD} owner_t;

  state_t          state, state_next;
  owner_t          owner, grant_owner;
  logic [BW-1:0]   beat_cnt, beat_limit;
  logic [SW-1:0]   starve_cnt;
  logic [15:0]     low_half;
  logic [14:0]     vid_word;
  logic            cache_pend, starved, grant, ack_hit, xfer_open, beat_in, beat_take;

  assign cache_pend = cache_wr_req | cache_rd_req;
  assign starved    = (starve_cnt == SW'(STARVE_MAX)) && cache_pend;
  // Inverting the upper bits walks the framebuffer downwards from the top of the window.
  assign vid_word   = VID_BASE + {3'b000, ~vid_adr[11:2], vid_adr[1:0]};
  assign ack_hit    = (state == ISSUE) && (sys_cmd_ack == sys_cmd);
  assign beat_limit = (owner == OWN_VID) ? BW'(VID_BEATS) : BW'(LINE_BEATS);
  assign xfer_open  = (state == XFER) && (beat_cnt != beat_limit);
  assign beat_in    = (owner == OWN_CWR) ? sys_wr_data_valid : sys_rd_data_valid;
  assign beat_take  = xfer_open && beat_in;

  always_comb begin
    grant       = 1'b0;
    grant_owner = OWN_VID;
    if (starved) begin
      grant       = 1'b1;
      grant_owner = cache_wr_req ? OWN_CWR : OWN_CRD;
    end else if (vid_req) begin
      grant       = 1'b1;
      grant_owner = OWN_VID;
    end else if (cache_wr_req) begin
      grant       = 1'b1;
      grant_owner = OWN_CWR;
    end else if (cache_rd_req) begin
      grant       = 1'b1;
      grant_owner = OWN_CRD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   if (ack_hit) state_next = XFER;
      XFER:    if (beat_cnt == beat_limit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    cache_fill_we  = xfer_open && (owner == OWN_CRD) && sys_rd_data_valid;
    cache_drain_re = xfer_open && (owner == OWN_CWR) && sys_wr_data_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_cmd    <= 2'b00;
      sys_addr   <= '0;
      owner      <= OWN_VID;
      starve_cnt <= '0;
      beat_cnt   <= '0;
      vid_adr    <= '0;
      low_half   <= '0;
      vq_we      <= 1'b0;
      vq_data    <= '0;
    end else begin
      vq_we <= 1'b0;
      if (state == IDLE) begin
        if (grant) begin
          owner <= grant_owner;
          case (grant_owner)
            OWN_VID: begin sys_cmd <= 2'b10; sys_addr <= {vid_word, 3'b000}; end
            OWN_CWR: begin sys_cmd <= 2'b01; sys_addr <= {cache_waddr, 6'b0}; end
            default: begin sys_cmd <= 2'b11; sys_addr <= {cache_raddr, 6'b0}; end
          endcase
        end
        if (grant && grant_owner != OWN_VID)
          starve_cnt <= '0;
        else if (!cache_pend)
          starve_cnt <= '0;
        else if (grant && starve_cnt != SW'(STARVE_MAX))
          starve_cnt <= starve_cnt + 1'b1;
      end
      if (ack_hit) begin
        sys_cmd  <= 2'b00;
        beat_cnt <= '0;
        if (owner == OWN_VID)
          vid_adr <= (vid_adr == VID_LAST) ? 12'd0 : vid_adr + 12'd1;
      end
      if (beat_take) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (owner == OWN_VID) begin
          if (!beat_cnt[0]) begin
            low_half <= sys_dout;
          end else begin
            vq_we   <= 1'b1;
            vq_data <= {sys_dout, low_half};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Directed bench for sdram_cmd_sched: arbitration order, starvation override,
// address formation, beat routing, ack handling, video wrap and mid-transfer reset.
module tb_sdram_cmd_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req, cache_wr_req, cache_rd_req;
  logic [11:0] cache_waddr, cache_raddr;
  logic [1:0]  sys_cmd;
  logic [17:0] sys_addr;
  logic [1:0]  sys_cmd_ack;
  logic        sys_rd_data_valid, sys_wr_data_valid;
  logic [15:0] sys_dout;
  logic        cache_fill_we, cache_drain_re, vq_we;
  logic [31:0] vq_data;
  logic [11:0] vid_adr;
  logic        busy;

  sdram_cmd_sched dut (
    .clk(clk), .rst(rst), .vid_req(vid_req), .cache_wr_req(cache_wr_req),
    .cache_rd_req(cache_rd_req), .cache_waddr(cache_waddr), .cache_raddr(cache_raddr),
    .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
    .sys_dout(sys_dout), .cache_fill_we(cache_fill_we), .cache_drain_re(cache_drain_re),
    .vq_we(vq_we), .vq_data(vq_data), .vid_adr(vid_adr), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fill_n = 0;
  int drain_n = 0;
  logic [31:0] vq_log[$];
  logic [11:0] vid_exp = 12'd0;

  always @(negedge clk) begin
    if (cache_fill_we) fill_n++;
    if (cache_drain_re) drain_n++;
    if (vq_we) vq_log.push_back(vq_data);
  end

  function automatic logic [17:0] vid_addr_of(input logic [11:0] v);
    logic [14:0] w;
    w = 15'h6FF8 + {3'b000, ~v[11:2], v[1:0]};
    return {w, 3'b000};
  endfunction

  task automatic wait_cmd(output logic [1:0] cmd, output logic [17:0] addr, output bit ok);
    ok = 0; cmd = 2'b00; addr = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sys_cmd != 2'b00) begin
        cmd = sys_cmd; addr = sys_addr; ok = 1;
        break;
      end
    end
  endtask

  task automatic finish_txn(input logic [1:0] cmd, output bit ok);
    int n;
    n = (cmd == 2'b10) ? 16 : 128;
    sys_cmd_ack = cmd;
    @(posedge clk); #1;
    sys_cmd_ack = 2'b00;
    for (int i = 0; i < n; i++) begin
      if (cmd == 2'b01) sys_wr_data_valid = 1'b1;
      else begin sys_rd_data_valid = 1'b1; sys_dout = 16'(i + 1); end
      @(posedge clk); #1;
    end
    sys_wr_data_valid = 1'b0;
    sys_rd_data_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (!busy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (cmd == 2'b10) vid_exp = (vid_exp == 12'd3071) ? 12'd0 : vid_exp + 12'd1;
  endtask

  task automatic test_reset;
    rst = 1'b1; vid_req = 0; cache_wr_req = 0; cache_rd_req = 0;
    cache_waddr = '0; cache_raddr = '0; sys_cmd_ack = 2'b00;
    sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (sys_cmd !== 2'b00) begin bad++; $display("FAIL reset_cmd got=%h want=0", sys_cmd); end
    total++; if (sys_addr !== 18'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", sys_addr); end
    total++; if (vid_adr !== 12'h0) begin bad++; $display("FAIL reset_vid_adr got=%h want=0", vid_adr); end
    total++; if (vq_data !== 32'h0) begin bad++; $display("FAIL reset_vq_data got=%h want=0", vq_data); end
    total++; if ({cache_fill_we, cache_drain_re, vq_we} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b want=000", {cache_fill_we, cache_drain_re, vq_we}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_video_single;
    logic [1:0] cmd; logic [17:0] addr; bit ok; int base;
    vid_req = 1;
    wait_cmd(cmd, addr, ok);
    vid_req = 0;
    total++; if (!ok || cmd !== 2'b10) begin bad++; $display("FAIL vid_cmd got=%h ok=%0d want=2", cmd, ok); end
    total++; if (addr !== 18'h3FFA0) begin bad++; $display("FAIL vid_addr got=%h want=3ffa0", addr); end
    base = vq_log.size();
    finish_txn(cmd, ok);
    total++; if (!ok) begin bad++; $display("FAIL vid_idle_timeout got=busy want=idle"); end
    total++; if (vq_log.size() - base != 8) begin bad++; $display("FAIL vid_vq_count got=%0d want=8", vq_log.size() - base); end
    total++;
    if (vq_log.size() < base + 8) begin bad++; $display("FAIL vid_vq_words got=%0d words want=8", vq_log.size() - base); end
    else if (vq_log[base] !== 32'h00020001 || vq_log[base+7] !== 32'h0010000F) begin
      bad++; $display("FAIL vid_vq_data got=%h/%h want=00020001/0010000f", vq_log[base], vq_log[base+7]);
    end
    total++; if (vid_adr !== 12'd1) begin bad++; $display("FAIL vid_adr_inc got=%0d want=1", vid_adr); end
  endtask

  task automatic test_priority;
    logic [1:0] cmd; logic [17:0] addr; bit ok; int d0, f0;
    cache_waddr = 12'hA5C; cache_raddr = 12'h3C1;
    vid_req = 1; cache_wr_req = 1; cache_rd_req = 1;
    wait_cmd(cmd, addr, ok);
    vid_req = 0;
    total++; if (cmd !== 2'b10) begin bad++; $display("FAIL prio_first got=%h want=2", cmd); end
    total++; if (addr !== vid_addr_of(vid_exp)) begin bad++; $display("FAIL prio_vid_addr got=%h want=%h", addr, vid_addr_of(vid_exp)); end
    finish_txn(cmd, ok);
    wait_cmd(cmd, addr, ok);
    cache_wr_req = 0;
    total++; if (cmd !== 2'b01) begin bad++; $display("FAIL prio_second got=%h want=1", cmd); end
    total++; if (addr !== {12'hA5C, 6'b0}) begin bad++; $display("FAIL prio_cwr_addr got=%h want=%h", addr, {12'hA5C, 6'b0}); end
    d0 = drain_n; f0 = fill_n;
    finish_txn(cmd, ok);
    total++; if (drain_n - d0 != 128 || fill_n != f0) begin bad++; $display("FAIL prio_drain got=%0d/%0d want=128/0", drain_n - d0, fill_n - f0); end
    wait_cmd(cmd, addr, ok);
    cache_rd_req = 0;
    total++; if (cmd !== 2'b11) begin bad++; $display("FAIL prio_third got=%h want=3", cmd); end
    total++; if (addr !== {12'h3C1, 6'b0}) begin bad++; $display("FAIL prio_crd_addr got=%h want=%h", addr, {12'h3C1, 6'b0}); end
    f0 = fill_n;
    finish_txn(cmd, ok);
    total++; if (fill_n - f0 != 128) begin bad++; $display("FAIL prio_fill got=%0d want=128", fill_n - f0); end
  endtask

  task automatic test_starve;
    logic [1:0] cmd; logic [17:0] addr; bit ok;
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    cache_raddr = 12'h055;
    vid_req = 1; cache_rd_req = 1;
    for (int k = 0; k < 6; k++) begin
      wait_cmd(cmd, addr, ok);
      if (cmd == 2'b11) cache_rd_req = 0;
      if (k == 5) vid_req = 0;
      total++; if (!ok || cmd !== exp_seq[k]) begin bad++; $display("FAIL starve_grant%0d got=%h want=%h", k, cmd, exp_seq[k]); end
      finish_txn(cmd, ok);
      if (k == 3) begin
        total++; if (dut.starve_cnt !== 3'd4) begin bad++; $display("FAIL starve_sat got=%0d want=4", dut.starve_cnt); end
      end
      if (k == 4) begin
        total++; if (dut.starve_cnt !== 3'd0) begin bad++; $display("FAIL starve_clear got=%0d want=0", dut.starve_cnt); end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL starve_idle got=%b want=0", busy); end
  endtask

  task automatic test_ack_hold;
    logic [1:0] cmd; logic [17:0] addr; bit ok; int f0, base;
    vid_req = 1;
    wait_cmd(cmd, addr, ok);
    vid_req = 0;
    total++; if (!ok || addr !== vid_addr_of(vid_exp)) begin bad++; $display("FAIL hold_addr got=%h want=%h", addr, vid_addr_of(vid_exp)); end
    f0 = fill_n; base = vq_log.size();
    for (int i = 0; i < 20; i++) begin
      sys_rd_data_valid = (i % 3 == 0);
      sys_dout = 16'hDEAD;
      sys_cmd_ack = (i >= 10 && i < 13) ? 2'b11 : 2'b00;
      @(posedge clk); #1;
      total++; if (sys_cmd !== cmd || sys_addr !== addr || busy !== 1'b1) begin
        bad++; $display("FAIL hold_stable%0d got=%h/%h/%b want=%h/%h/1", i, sys_cmd, sys_addr, busy, cmd, addr);
      end
    end
    sys_rd_data_valid = 0; sys_cmd_ack = 2'b00;
    total++; if (fill_n != f0 || vq_log.size() != base) begin bad++; $display("FAIL hold_stray got=%0d/%0d want=0/0", fill_n - f0, vq_log.size() - base); end
    finish_txn(cmd, ok);
    total++;
    if (vq_log.size() - base != 8) begin bad++; $display("FAIL hold_vq_count got=%0d want=8", vq_log.size() - base); end
    else if (vq_log[base] !== 32'h00020001) begin bad++; $display("FAIL hold_vq_first got=%h want=00020001", vq_log[base]); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] cmd; logic [17:0] addr; bit ok; int f0, d0;
    cache_raddr = 12'h123; cache_rd_req = 1;
    wait_cmd(cmd, addr, ok);
    cache_rd_req = 0;
    total++; if (cmd !== 2'b11) begin bad++; $display("FAIL rmid_cmd got=%h want=3", cmd); end
    sys_cmd_ack = cmd;
    @(posedge clk); #1;
    sys_cmd_ack = 2'b00;
    f0 = fill_n;
    for (int i = 0; i < 5; i++) begin
      sys_rd_data_valid = 1; sys_dout = 16'(i + 1);
      @(posedge clk); #1;
    end
    total++; if (fill_n - f0 != 5) begin bad++; $display("FAIL rmid_pre got=%0d want=5", fill_n - f0); end
    rst = 1'b1;
    #1;
    vid_exp = 12'd0;
    total++; if (sys_cmd !== 2'b00 || sys_addr !== 18'h0 || vid_adr !== 12'h0 || vq_data !== 32'h0) begin
      bad++; $display("FAIL rmid_outs got=%h/%h/%h/%h want=0/0/0/0", sys_cmd, sys_addr, vid_adr, vq_data);
    end
    total++; if ({cache_fill_we, cache_drain_re, vq_we, busy} !== 4'b0000) begin
      bad++; $display("FAIL rmid_strobes got=%b want=0000", {cache_fill_we, cache_drain_re, vq_we, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    f0 = fill_n;
    repeat (4) begin @(posedge clk); #1; end
    sys_rd_data_valid = 0;
    total++; if (fill_n != f0) begin bad++; $display("FAIL rmid_post got=%0d want=0", fill_n - f0); end
    cache_waddr = 12'h7E0; cache_wr_req = 1;
    wait_cmd(cmd, addr, ok);
    cache_wr_req = 0;
    total++; if (!ok || cmd !== 2'b01 || addr !== {12'h7E0, 6'b0}) begin
      bad++; $display("FAIL rmid_regrant got=%h/%h want=1/%h", cmd, addr, {12'h7E0, 6'b0});
    end
    d0 = drain_n;
    finish_txn(cmd, ok);
    total++; if (drain_n - d0 != 128) begin bad++; $display("FAIL rmid_drain got=%0d want=128", drain_n - d0); end
  endtask

  task automatic test_wrap;
    logic [1:0] cmd; logic [17:0] addr; bit ok;
    while (vid_exp != 12'd3071) begin
      vid_req = 1;
      wait_cmd(cmd, addr, ok);
      vid_req = 0;
      total++;
      if (!ok || cmd !== 2'b10) begin bad++; $display("FAIL wrap_step%0d got=%h want=2", vid_exp, cmd); break; end
      finish_txn(cmd, ok);
    end
    total++; if (vid_adr !== 12'd3071) begin bad++; $display("FAIL wrap_preset got=%0d want=3071", vid_adr); end
    vid_req = 1;
    wait_cmd(cmd, addr, ok);
    vid_req = 0;
    total++; if (!ok || addr !== 18'h39FD8) begin bad++; $display("FAIL wrap_last_addr got=%h want=39fd8", addr); end
    finish_txn(cmd, ok);
    total++; if (vid_adr !== 12'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", vid_adr); end
  endtask

  initial begin
    test_reset;
    test_video_single;
    test_priority;
    test_starve;
    test_ack_hold;
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
